// File: rtl/ecc_pkg.sv
// Shared constants for the curve25519 field arithmetic blocks.
// The tag width helper sizes the requester-id tags that travel alongside products.
package ecc_pkg;

    localparam int ECC_W = 255;

    // q = 2^255 - 19
    localparam logic [ECC_W-1:0] Q =
        255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;
    localparam logic [ECC_W-1:0] Q_MINUS_2 =
        255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffeb;

    // Never returns less than 1 so a single-bit tag still exists for tiny configs.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mul_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each product still inside the ModMul.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module mul_tag_fifo
    import ecc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, rd_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one pipelined ModMul among N_REQ requesters, with grant lock
// for back-to-back chains and an in-order tag FIFO that steers each product home.
module modmul_arbiter
    import ecc_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int W         = ECC_W,
    parameter int TAG_DEPTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ-1:0]   i_req_lock,
    input  logic [N_REQ*W-1:0] i_req_x,
    input  logic [N_REQ*W-1:0] i_req_y,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [N_REQ-1:0]   o_rsp_valid,
    output logic [W-1:0]       o_rsp_data,
    output logic               o_mul_valid,
    output logic [W-1:0]       o_mul_x,
    output logic [W-1:0]       o_mul_y,
    input  logic               i_mul_valid,
    input  logic [W-1:0]       i_mul_data
);

    localparam int          TW = clog2(N_REQ);
    localparam logic [TW:0] NR = (TW+1)'(N_REQ);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [TW-1:0]    rr_q, rr_d, own_q, own_d, grant, scan, tag_out;
    logic [TW:0]      sum, nxt;
    logic             lock_q, lock_d, grant_vld, xfer, pop, fifo_full, fifo_empty, err_q;
    logic             mul_valid_q;
    logic [W-1:0]     mul_x_q, mul_y_q, rsp_data_q;
    logic [N_REQ-1:0] rsp_valid_q;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Scan downward so the requester closest to rr_q is the last (winning) assignment.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        scan      = '0;
        if (lock_q) begin
            grant     = own_q;
            grant_vld = i_req_valid[own_q];
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                sum = {1'b0, rr_q} + (TW+1)'(k);
                if (sum >= NR) sum = sum - NR;
                scan = sum[TW-1:0];
                if (i_req_valid[scan]) begin
                    grant     = scan;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign xfer        = rst_int_n && grant_vld && !fifo_full;
    assign o_req_ready = xfer ? (N_REQ'(1) << grant) : '0;
    assign pop         = i_mul_valid && !fifo_empty;
    assign nxt         = {1'b0, grant} + (TW+1)'(1);

    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        own_d  = own_q;
        if (xfer) begin
            if (i_req_lock[grant]) begin
                lock_d = 1'b1;
                own_d  = grant;
            end else begin
                lock_d = 1'b0;
                rr_d   = (nxt == NR) ? '0 : nxt[TW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            own_q       <= '0;
            mul_valid_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            own_q       <= own_d;
            mul_valid_q <= xfer;
            if (xfer) begin
                mul_x_q <= i_req_x[int'(grant)*W +: W];
                mul_y_q <= i_req_y[int'(grant)*W +: W];
            end
            rsp_valid_q <= pop ? (N_REQ'(1) << tag_out) : '0;
            if (pop) rsp_data_q <= i_mul_data;
            if (i_mul_valid && fifo_empty) err_q <= 1'b1;
        end
    end

    mul_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .DW    (TW)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (rst_int_n),
        .i_push  (xfer),
        .i_data  (grant),
        .i_pop   (pop),
        .o_data  (tag_out),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_mul_valid = mul_valid_q;
    assign o_mul_x     = mul_x_q;
    assign o_mul_y     = mul_y_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;

    // A requester stuck behind a full FIFO must not change operands while it keeps valid up.
    for (genvar r = 0; r < N_REQ; r++) begin : g_hold
        a_hold: assert property (@(posedge i_clk) disable iff (!rst_int_n)
            (i_req_valid[r] && fifo_full) |=>
            (!i_req_valid[r] || ($stable(i_req_x[r*W +: W]) && $stable(i_req_y[r*W +: W]))));
    end

    a_no_orphan: assert property (@(posedge i_clk) disable iff (!rst_int_n) !err_q);

endmodule
